controle_banco_registro: RTL and testbench
==========================================

Name: controle_banco_registro

Overview:
Multi-cycle register-access sequencer, the initiator side of the Banco_Registro port set. Accepts one 16-bit instruction per valid/ready handshake and decodes it. Reads both operands through Sel_E_SA/Sel_SB and A/B, computes in an internal ALU, then writes back through Hab_Escrita/Sel_E_SA/E. It is the control path that turns the register bank into a minimal 4-register datapath.

Parameters:
bits_palavra, 16, data word width; the instruction format is fixed for 16.
end_registros, 2, register address width; must match Banco_Registro.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; one clock, reset synchronous active-high (fixed)
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer idle, accepts instruction this cycle
instr  in  16  [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8
Hab_Escrita  out  1  write enable to register bank
Sel_E_SA  out  end_registros  write address / read port A address (= rd)
Sel_SB  out  end_registros  read port B address (= rs)
E  out  bits_palavra  write data to register bank
A  in  bits_palavra  read data port A from register bank
B  in  bits_palavra  read data port B from register bank
concluido  out  1  one-cycle pulse, instruction retired
resultado  out  bits_palavra  last computed result, held until the next retire
flag_zero  out  1  resultado == 0 at last write
flag_carry  out  1  carry/borrow of last ADD/SUB
erro  out  1  one-cycle pulse with concluido for an illegal opcode

Behaviour:
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rd+rs.
  - 2 SUB: rd=rd-rs.
  - 3 AND. 4 OR. 5 XOR.
  - 6 MOV: rd=rs.
  - 7 LDI: rd={8'h00,imm8}.
  - 8 LDH: rd={imm8,rd[7:0]}.
  - 9 NOT: rd=~rs.
  - 10-15 illegal.
- States: OCIOSO, LEITURA, EXECUCAO, ESCRITA, CONCLUIDO.
- instr_ready = (estado==OCIOSO). Handshake completes when instr_valid && instr_ready at a clock edge. instr is latched then, and instr is don't-care afterwards.
- OCIOSO -> LEITURA on handshake.
- LEITURA: Sel_E_SA=rd, Sel_SB=rs, Hab_Escrita=0. A/B are latched into operand registers at the end of the cycle. This is mandatory because the bank freezes A while Hab_Escrita=1.
- EXECUCAO: ALU result is registered.
  - Next state is ESCRITA for opcodes 1-9.
  - Next state is CONCLUIDO for NOP and illegal opcodes, with no write.
- ESCRITA: Hab_Escrita=1, Sel_E_SA=rd, E=result. The bank captures at the end of this cycle. Flags update here.
- CONCLUIDO: concluido=1 for exactly one cycle. resultado updates for opcodes 1-9. erro=1 for illegal opcodes. Then -> OCIOSO.
- Latency: handshake at edge N; write captured at edge N+3; concluido high in cycle N+4; next handshake possible at edge N+5. NOP/illegal: concluido in cycle N+3.
- Outputs outside their state: Hab_Escrita=0, E=0, Sel_* hold the last values.
- Arithmetic:
  - ADD flag_carry = bit 16 of the 17-bit sum.
  - SUB computes rd + ~rs + 1; flag_carry = borrow = (rd < rs unsigned).
  - flag_carry holds for non-ADD/SUB opcodes.
  - flag_zero updates on every write.
  - All results wrap modulo 2^16.
- rd == rs is legal. Example: SUB r1,r1 -> 0, flag_zero=1, flag_carry=0.
- Reset values: estado=OCIOSO, Hab_Escrita=0, Sel_E_SA=0, Sel_SB=0, E=0, concluido=0, resultado=0, flags=0, erro=0.
- Reset mid-operation: next state is OCIOSO with no later write.
  - If reset is high during ESCRITA, the write at that edge still commits, since Hab_Escrita was already 1 in that cycle.
  - concluido is never asserted for an aborted instruction.
- instr_valid while busy is ignored; the source must hold it.

Decomposition:
- Package controle_pkg:
  - opcode_t enum (NOP..NOT).
  - estado_t enum.
  - Field position constants OP_MSB/OP_LSB, RD_*, RS_*, IMM_*.
  - Function is_escrita(opcode).
- Sub-module ula_controle: purely combinational. Inputs opcode, op_a, op_b, imm8. Outputs result, carry.

Test Plan:
- reset, then LDI r1,0x34 (instr 0x7434) -> Hab_Escrita=1 with Sel_E_SA=1, E=0x0034 three edges after handshake; concluido one cycle later; resultado=0x0034, flag_zero=0.
- LDH r1,0x12 (0x8412) after the above, with A=0x0034 in LEITURA -> E=0x1234; resultado=0x1234.
- ADD r2,r3 with bank r2=0xFFFF, r3=0x0001 (0x1B00) -> E=0x0000, flag_zero=1, flag_carry=1.
- SUB r0,r1 with r0=0x0005, r1=0x0007 -> E=0xFFFE, flag_carry=1; then AND -> flag_carry stays 1.
- opcode 0xF (0xF000) -> no Hab_Escrita pulse, concluido and erro high same cycle, resultado unchanged; NOP likewise without erro.
- reset asserted in EXECUCAO of ADD -> no Hab_Escrita, no concluido, instr_ready=1 next cycle. Back-to-back valid held high -> exactly one instruction every 5 cycles.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared types, instruction field positions and opcode helpers for the
// register-bank sequencer.
package controle_pkg;

  // Opcodes carried in instr[15:12]; values 10-15 are illegal.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_MOV = 4'd6,
    OP_LDI = 4'd7,
    OP_LDH = 4'd8,
    OP_NOT = 4'd9
  } opcode_t;

  // Sequencer states, one per phase of an instruction.
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    LEITURA   = 3'd1,
    EXECUCAO  = 3'd2,
    ESCRITA   = 3'd3,
    CONCLUIDO = 3'd4
  } estado_t;

  // Instruction field positions (format fixed at 16 bits).
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // True for opcodes that write rd back to the bank (ADD..NOT).
  function automatic logic is_escrita(input logic [3:0] opcode);
    return (opcode >= 4'(OP_ADD)) && (opcode <= 4'(OP_NOT));
  endfunction

  // True for opcodes whose carry/borrow updates flag_carry.
  function automatic logic is_aritmetica(input logic [3:0] opcode);
    return (opcode == 4'(OP_ADD)) || (opcode == 4'(OP_SUB));
  endfunction

  // True for opcodes outside the defined set.
  function automatic logic is_ilegal(input logic [3:0] opcode);
    return opcode > 4'(OP_NOT);
  endfunction

endpackage

// File: rtl/ula_controle.sv
// Combinational ALU of the sequencer: computes the write-back value and the
// carry/borrow from the latched operands and the immediate byte.
module ula_controle
  import controle_pkg::*;
#(
  parameter int bits_palavra = 16
) (
  input  logic [3:0]              opcode,
  input  logic [bits_palavra-1:0] op_a,
  input  logic [bits_palavra-1:0] op_b,
  input  logic [7:0]              imm8,
  output logic [bits_palavra-1:0] result,
  output logic                    carry
);

  logic [bits_palavra:0]   soma;
  logic [bits_palavra:0]   diferenca;
  logic [bits_palavra-1:0] imm_ext;
  logic [bits_palavra-1:0] mascara_baixa;

  // Subtraction is done as a + ~b + 1 so the carry-out is the inverted borrow.
  assign soma          = {1'b0, op_a} + {1'b0, op_b};
  assign diferenca     = {1'b0, op_a} + {1'b0, ~op_b} + (bits_palavra + 1)'(1);
  assign imm_ext       = bits_palavra'(imm8);
  assign mascara_baixa = bits_palavra'(8'hFF);

  // Opcode decode into result and carry; unused opcodes give zero.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = soma[bits_palavra-1:0];
        carry  = soma[bits_palavra];
      end
      OP_SUB: begin
        result = diferenca[bits_palavra-1:0];
        carry  = ~diferenca[bits_palavra];
      end
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_MOV: result = op_b;
      OP_LDI: result = imm_ext;
      OP_LDH: result = (op_a & mascara_baixa) | (imm_ext << (bits_palavra - 8));
      OP_NOT: result = ~op_b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controle_banco_registro.sv
// Multi-cycle sequencer driving a 4-register bank: accepts one instruction per
// handshake, reads rd/rs, computes in ula_controle and writes rd back.
module controle_banco_registro
  import controle_pkg::*;
#(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [15:0]              instr,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_E_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [bits_palavra-1:0]  E,
  input  logic [bits_palavra-1:0]  A,
  input  logic [bits_palavra-1:0]  B,
  output logic                     concluido,
  output logic [bits_palavra-1:0]  resultado,
  output logic                     flag_zero,
  output logic                     flag_carry,
  output logic                     erro
);

  estado_t                  estado_q, estado_d;
  logic [3:0]               opcode_q;
  logic [7:0]               imm_q;
  logic [end_registros-1:0] sel_a_q;
  logic [end_registros-1:0] sel_b_q;
  logic [bits_palavra-1:0]  op_a_q;
  logic [bits_palavra-1:0]  op_b_q;
  logic [bits_palavra-1:0]  res_q;
  logic                     carry_q;
  logic [bits_palavra-1:0]  resultado_q;
  logic                     flag_zero_q;
  logic                     flag_carry_q;

  logic [bits_palavra-1:0]  ula_result;
  logic                     ula_carry;
  logic                     handshake;

  assign handshake = instr_valid && (estado_q == OCIOSO);

  ula_controle #(
    .bits_palavra(bits_palavra)
  ) u_ula (
    .opcode (opcode_q),
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .imm8   (imm_q),
    .result (ula_result),
    .carry  (ula_carry)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state sequencing and per-state control outputs.
  always_comb begin
    estado_d    = estado_q;
    instr_ready = 1'b0;
    Hab_Escrita = 1'b0;
    concluido   = 1'b0;
    erro        = 1'b0;
    case (estado_q)
      OCIOSO: begin
        instr_ready = 1'b1;
        if (instr_valid) estado_d = LEITURA;
      end
      LEITURA: begin
        estado_d = EXECUCAO;
      end
      EXECUCAO: begin
        estado_d = is_escrita(opcode_q) ? ESCRITA : CONCLUIDO;
      end
      ESCRITA: begin
        Hab_Escrita = 1'b1;
        estado_d    = CONCLUIDO;
      end
      CONCLUIDO: begin
        concluido = 1'b1;
        erro      = is_ilegal(opcode_q);
        estado_d  = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Latch the instruction fields at the handshake; the selects then hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q <= '0;
      imm_q    <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
    end else if (handshake) begin
      opcode_q <= instr[OP_MSB:OP_LSB];
      imm_q    <= instr[IMM_MSB:IMM_LSB];
      sel_a_q  <= end_registros'(instr[RD_MSB:RD_LSB]);
      sel_b_q  <= end_registros'(instr[RS_MSB:RS_LSB]);
    end
  end

  // Capture both read ports during LEITURA, before the bank freezes A for the write.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (estado_q == LEITURA) begin
      op_a_q <= A;
      op_b_q <= B;
    end
  end

  // Register the ALU output so the write cycle drives E from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (estado_q == EXECUCAO) begin
      res_q   <= ula_result;
      carry_q <= ula_carry;
    end
  end

  // Retire state: visible result and flags update with the write itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      resultado_q  <= '0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else if (estado_q == ESCRITA) begin
      resultado_q <= res_q;
      flag_zero_q <= (res_q == '0);
      if (is_aritmetica(opcode_q)) flag_carry_q <= carry_q;
    end
  end

  // Write data is forced to zero whenever no write is in progress.
  for (genvar gi = 0; gi < bits_palavra; gi++) begin : g_saida_e
    assign E[gi] = Hab_Escrita & res_q[gi];
  end

  assign Sel_E_SA   = sel_a_q;
  assign Sel_SB     = sel_b_q;
  assign resultado  = resultado_q;
  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;

endmodule

// File: tb/tb_controle_banco_registro.sv
// Randomised and directed bench for controle_banco_registro with a
// behavioural register bank and an architectural reference model.
module tb_controle_banco_registro;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        Hab_Escrita;
  logic [1:0]  Sel_E_SA;
  logic [1:0]  Sel_SB;
  logic [15:0] E;
  logic [15:0] A;
  logic [15:0] B;
  logic        concluido;
  logic [15:0] resultado;
  logic        flag_zero;
  logic        flag_carry;
  logic        erro;

  int checks   = 0;
  int failures = 0;

  // Register bank seen by the DUT, and the architectural reference state.
  logic [15:0] bank [4] = '{default: 16'h0000};
  logic [15:0] ref_regs [4];
  logic [15:0] exp_resultado;
  logic        exp_zero;
  logic        exp_carry;

  controle_banco_registro #(
    .bits_palavra (16),
    .end_registros(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .Hab_Escrita(Hab_Escrita),
    .Sel_E_SA   (Sel_E_SA),
    .Sel_SB     (Sel_SB),
    .E          (E),
    .A          (A),
    .B          (B),
    .concluido  (concluido),
    .resultado  (resultado),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .erro       (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign A = bank[Sel_E_SA];
  assign B = bank[Sel_SB];

  always @(posedge clock) begin
    if (Hab_Escrita) bank[Sel_E_SA] <= E;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the sequencer to be idle, returning on a falling edge.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready", 32'(instr_ready), 1);
  endtask

  // Issues one instruction, watches five cycles after the handshake and
  // compares timing, bus values and architectural state with the model.
  task automatic issue(input logic [15:0] ins);
    int   op, rd, rs, imm, a, b, r;
    bit   wr, illegal;
    int   wr_cnt, wr_cyc, done_cnt, done_cyc, stray_erro;
    logic [15:0] e_seen;
    logic [1:0]  sel_seen;
    logic        erro_seen;

    op  = int'(ins[15:12]);
    rd  = int'(ins[11:10]);
    rs  = int'(ins[9:8]);
    imm = int'(ins[7:0]);
    a   = int'(ref_regs[rd]);
    b   = int'(ref_regs[rs]);
    wr  = 1'b1;
    illegal = 1'b0;
    r   = 0;
    case (op)
      0: wr = 1'b0;
      1: begin r = a + b; exp_carry = (r > 65535); end
      2: begin r = a - b; exp_carry = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = b;
      7: r = imm;
      8: r = imm * 256 + (a % 256);
      9: r = ~b;
      default: begin wr = 1'b0; illegal = 1'b1; end
    endcase
    r = r & 32'hFFFF;

    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clock);

    wr_cnt = 0; wr_cyc = 0; done_cnt = 0; done_cyc = 0; stray_erro = 0;
    e_seen = '0; sel_seen = '0; erro_seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        check("rd_sel", 32'(Sel_E_SA), rd);
        check("rs_sel", 32'(Sel_SB), rs);
        check("busy", 32'(instr_ready), 0);
      end
      if (Hab_Escrita) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          wr_cyc   = k;
          e_seen   = E;
          sel_seen = Sel_E_SA;
        end
      end else begin
        check("e_idle", 32'(E), 0);
      end
      if (concluido) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc  = k;
          erro_seen = erro;
        end
      end else if (erro) begin
        stray_erro++;
      end
    end

    if (wr) begin
      ref_regs[rd]  = 16'(r);
      exp_resultado = 16'(r);
      exp_zero      = (r == 0);
      check("wr_cnt", 32'(wr_cnt), 1);
      check("wr_cyc", 32'(wr_cyc), 3);
      check("wr_data", 32'(e_seen), r);
      check("wr_addr", 32'(sel_seen), rd);
      check("done_cyc", 32'(done_cyc), 4);
    end else begin
      check("wr_cnt", 32'(wr_cnt), 0);
      check("done_cyc", 32'(done_cyc), 3);
    end
    check("done_cnt", 32'(done_cnt), 1);
    check("erro", 32'(erro_seen), 32'(illegal));
    check("erro_stray", 32'(stray_erro), 0);
    check("resultado", 32'(resultado), 32'(exp_resultado));
    check("flag_zero", 32'(flag_zero), 32'(exp_zero));
    check("flag_carry", 32'(flag_carry), 32'(exp_carry));
    check("bank_rd", 32'(bank[rd]), 32'(ref_regs[rd]));
    $display("instr=0x%04h op=%0d rd=%0d rs=%0d wr=%0d res=0x%04h z=%0d c=%0d",
             ins, op, rd, rs, wr, resultado, flag_zero, flag_carry);
  endtask

  // Reset in EXECUCAO of an ADD: no write, no completion, idle right after.
  task automatic abort_in_execucao(input logic [15:0] ins);
    int wr_cnt, done_cnt;
    int rd;
    rd = int'(ins[11:10]);
    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_resultado = '0;
    exp_zero      = 1'b0;
    exp_carry     = 1'b0;
    check("abort_ready", 32'(instr_ready), 1);
    check("abort_resultado", 32'(resultado), 0);
    check("abort_flags", {30'd0, flag_zero, flag_carry}, 0);
    wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (Hab_Escrita) wr_cnt++;
      if (concluido) done_cnt++;
      @(negedge clock);
    end
    check("abort_wr", 32'(wr_cnt), 0);
    check("abort_done", 32'(done_cnt), 0);
    check("abort_bank", 32'(bank[rd]), 32'(ref_regs[rd]));
    $display("abort instr=0x%04h writes=%0d done=%0d", ins, wr_cnt, done_cnt);
  endtask

  // Holds instr_valid high: handshakes must come every fifth cycle.
  task automatic back_to_back(input logic [15:0] ins);
    int hs[$];
    int wr_cnt, done_cnt, rd;
    rd = int'(ins[11:10]);
    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k <= 20; k++) begin
      if (instr_ready) hs.push_back(k);
      if (Hab_Escrita) wr_cnt++;
      if (concluido) done_cnt++;
      @(negedge clock);
    end
    instr_valid = 1'b0;
    check("b2b_handshakes", 32'(hs.size()), 5);
    for (int i = 1; i < hs.size(); i++) check("b2b_spacing", 32'(hs[i] - hs[i-1]), 5);
    check("b2b_writes", 32'(wr_cnt), 4);
    check("b2b_done", 32'(done_cnt), 4);
    wait_ready();
    ref_regs[rd]  = {8'h00, ins[7:0]};
    exp_resultado = {8'h00, ins[7:0]};
    exp_zero      = (ins[7:0] == 8'h00);
    check("b2b_bank", 32'(bank[rd]), 32'(ref_regs[rd]));
    check("b2b_resultado", 32'(resultado), 32'(exp_resultado));
    $display("back_to_back instr=0x%04h handshakes=%0d writes=%0d", ins, hs.size(), wr_cnt);
  endtask

  initial begin
    logic [15:0] ri;
    for (int i = 0; i < 4; i++) ref_regs[i] = 16'h0000;
    exp_resultado = '0;
    exp_zero      = 1'b0;
    exp_carry     = 1'b0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_ready", 32'(instr_ready), 1);
    check("rst_hab", 32'(Hab_Escrita), 0);
    check("rst_sel", {28'd0, Sel_E_SA, Sel_SB}, 0);
    check("rst_e", 32'(E), 0);
    check("rst_done", {30'd0, concluido, erro}, 0);
    check("rst_resultado", 32'(resultado), 0);
    check("rst_flags", {30'd0, flag_zero, flag_carry}, 0);

    issue(16'h7434);  // LDI r1,0x34
    issue(16'h8412);  // LDH r1,0x12 -> 0x1234
    issue(16'h78FF);  // LDI r2,0xFF
    issue(16'h88FF);  // LDH r2,0xFF -> 0xFFFF
    issue(16'h7C01);  // LDI r3,1
    issue(16'h1B00);  // ADD r2,r3 -> 0, zero, carry
    issue(16'h7005);  // LDI r0,5
    issue(16'h7407);  // LDI r1,7
    issue(16'h2100);  // SUB r0,r1 -> 0xFFFE, borrow
    issue(16'h3100);  // AND r0,r1 -> carry holds
    issue(16'hF000);  // illegal
    issue(16'h0000);  // NOP
    issue(16'h2500);  // SUB r1,r1 -> 0, zero, no borrow

    abort_in_execucao(16'h1B00);
    back_to_back(16'h7C5A);

    for (int n = 0; n < 40; n++) begin
      ri = 16'($urandom);
      issue(ri);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
